// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Purpose  : Shared ALU definitions. Holds the multi-cycle unit state        |
// |            encoding and the signed/unsigned mode select values.           |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package alu_pkg;

    // Sequencer states of the multi-cycle arithmetic units.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mul_state_e;

    // Values of the per-operation mode select input.
    localparam logic MUL_MODE_SIGNED   = 1'b1;
    localparam logic MUL_MODE_UNSIGNED = 1'b0;

endpackage
`default_nettype wire

// File: rtl/mul_sign_fix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_sign_fix                                                    |
// | Purpose  : Combinational sign restore and truncation-overflow detect for  |
// |            a 2*WIDTH-bit unsigned magnitude result.                       |
// | Ports    : i_mag  [2W-1:0] unsigned magnitude                              |
// |            i_neg           negate the magnitude                            |
// |            i_sgn           1 = signed mode, 0 = unsigned mode              |
// |            o_res  [2W-1:0] signed/unsigned result                          |
// |            o_ovf           result does not fit in WIDTH bits               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mul_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_mag,
    input  logic               i_neg,
    input  logic               i_sgn,
    output logic [2*WIDTH-1:0] o_res,
    output logic               o_ovf
);
    import alu_pkg::*;

    logic [2*WIDTH-1:0] w_res;
    logic [WIDTH:0]     w_top_signed;
    logic               w_ovf_signed;
    logic               w_ovf_unsigned;

    // A zero magnitude negates to zero, so no negative zero can appear.
    assign w_res = i_neg ? (~i_mag + 1'b1) : i_mag;

    // Signed fit: the upper half plus the WIDTH-bit sign bit must be a pure
    // sign extension (all zeros or all ones).
    assign w_top_signed   = w_res[2*WIDTH-1:WIDTH-1];
    assign w_ovf_signed   = !((&w_top_signed) || !(|w_top_signed));
    assign w_ovf_unsigned = |w_res[2*WIDTH-1:WIDTH];

    assign o_res = w_res;
    assign o_ovf = (i_sgn == MUL_MODE_SIGNED) ? w_ovf_signed : w_ovf_unsigned;

endmodule
`default_nettype wire

// File: rtl/seq_multiplier_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_multiplier_param                                            |
// | Purpose  : Radix-2 shift-add sequential multiplier, signed or unsigned    |
// |            per operation, with start/busy/done handshake, full-width      |
// |            product, WIDTH-bit overflow flag and zero-operand shortcut.    |
// | Ports    : clk             rising-edge clock                               |
// |            reset           synchronous, active-low reset                   |
// |            start           request, sampled only while idle                |
// |            sgn             1 = two's-complement operands                   |
// |            A, B  [W-1:0]   multiplicand / multiplier                       |
// |            busy            operation in progress                           |
// |            done            one-cycle result-valid pulse                    |
// |            Res   [2W-1:0]  product, held until the next done               |
// |            OVF             product does not fit in WIDTH bits              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_multiplier_param #(
    parameter int WIDTH     = 32,
    parameter int ZERO_SKIP = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Res,
    output logic               OVF
);
    import alu_pkg::*;

    localparam int                 C_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    mul_state_e          r_state;
    mul_state_e          w_state_nxt;

    logic [WIDTH-1:0]    r_m;        // multiplicand magnitude
    logic [WIDTH-1:0]    r_q;        // multiplier magnitude, shifts out LSB first
    logic [WIDTH-1:0]    r_acc;      // upper half of the running product
    logic                r_neg;
    logic                r_sgn;
    logic [C_CNT_W-1:0]  r_count;
    logic [2*WIDTH-1:0]  r_res;
    logic                r_ovf;
    logic                r_done;

    logic                w_sgn_mode;
    logic [WIDTH-1:0]    w_mag_a;
    logic [WIDTH-1:0]    w_mag_b;
    logic                w_zero;
    logic [WIDTH:0]      w_sum;
    logic [2*WIDTH-1:0]  w_fix_res;
    logic                w_fix_ovf;

    assign w_sgn_mode = (sgn == MUL_MODE_SIGNED);

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    assign w_mag_a = (w_sgn_mode && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign w_mag_b = (w_sgn_mode && B[WIDTH-1]) ? (~B + 1'b1) : B;

    assign w_zero = (ZERO_SKIP != 0) && ((A == '0) || (B == '0));

    // The carry out of this add is shifted straight into acc, so it never
    // needs to be held across edges.
    assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    mul_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .i_mag (({r_acc, r_q})),
        .i_neg (r_neg),
        .i_sgn (r_sgn),
        .o_res (w_fix_res),
        .o_ovf (w_fix_ovf)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_zero ? FIX : RUN;
                end
            end
            RUN: begin
                if (r_count == C_CNT_ONE) begin
                    w_state_nxt = FIX;
                end
            end
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_m     <= '0;
            r_q     <= '0;
            r_acc   <= '0;
            r_neg   <= 1'b0;
            r_sgn   <= 1'b0;
            r_count <= '0;
            r_res   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m     <= w_mag_a;
                        // A zero Q leaves {acc,Q} = 0 for the shortcut path.
                        r_q     <= w_zero ? '0 : w_mag_b;
                        r_acc   <= '0;
                        r_neg   <= w_sgn_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_sgn   <= w_sgn_mode;
                        r_count <= C_CNT_INIT;
                    end
                end
                RUN: begin
                    r_acc   <= w_sum[WIDTH:1];
                    r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_count <= r_count - C_CNT_ONE;
                end
                FIX: begin
                    r_res  <= w_fix_res;
                    r_ovf  <= w_fix_ovf;
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign Res  = r_res;
    assign OVF  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_multiplier_param                                         |
// | Purpose  : Self-checking bench for seq_multiplier_param at WIDTH=8, with  |
// |            one instance using the zero shortcut and one without it.       |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seq_multiplier_param;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           start0, sgn0, busy0, done0, OVF0;
    logic [W-1:0]   A0, B0;
    logic [2*W-1:0] Res0;
    logic           start1, sgn1, busy1, done1, OVF1;
    logic [W-1:0]   A1, B1;
    logic [2*W-1:0] Res1;

    seq_multiplier_param #(.WIDTH(W), .ZERO_SKIP(1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .sgn(sgn0), .A(A0), .B(B0),
        .busy(busy0), .done(done0), .Res(Res0), .OVF(OVF0)
    );

    seq_multiplier_param #(.WIDTH(W), .ZERO_SKIP(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .sgn(sgn1), .A(A1), .B(B1),
        .busy(busy1), .done(done1), .Res(Res1), .OVF(OVF1)
    );

    typedef struct {
        logic           s;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic           ovf;
        int             lat;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] res;
        logic           ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tbl[18];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product from integer arithmetic.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [2*W-1:0] r, output logic o);
        int p;
        if (s) begin
            p = int'($signed(a)) * int'($signed(b));
            o = (p < -128) || (p > 127);
        end else begin
            p = int'(a) * int'(b);
            o = (p > 255);
        end
        r = p[2*W-1:0];
    endfunction

    // Scoreboard consumer: every done pops one expectation.
    always @(negedge clk) begin
        if (reset && done0) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 Res=%0h, expected no done at %0t", Res0, $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("res", int'(Res0), int'(mon_e.res));
                chk("ovf", int'(OVF0), int'(mon_e.ovf));
                chk("busy_in_done", int'(busy0), 0);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic launch0(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] r, input logic o);
        exp_t e;
        e.res = r;
        e.ovf = o;
        sgn0   = s;
        A0     = a;
        B0     = b;
        start0 = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        A0     = W'($urandom);
        B0     = W'($urandom);
        sgn0   = ~s;
        chk("busy_after_accept", int'(busy0), 1);
    endtask

    task automatic wait_done0(input int exp_lat);
        int n;
        n = 0;
        while (!done0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("latency0", n, exp_lat);
    endtask

    task automatic op1(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] r, input logic o, input int exp_lat);
        int n;
        @(negedge clk);
        sgn1 = s; A1 = a; B1 = b; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        A1 = W'($urandom);
        B1 = W'($urandom);
        n = 0;
        while (!done1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("latency1", n, exp_lat);
        chk("res1", int'(Res1), int'(r));
        chk("ovf1", int'(OVF1), int'(o));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int done_cnt;
        logic [2*W-1:0] r;
        logic o;

        reset = 1'b0;
        start0 = 1'b0; sgn0 = 1'b0; A0 = '0; B0 = '0;
        start1 = 1'b0; sgn1 = 1'b0; A1 = '0; B1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_res",  int'(Res0), 0);
        chk("rst_ovf",  int'(OVF0), 0);
        chk("rst_busy1", int'(busy1), 0);
        reset = 1'b1;

        // Random vectors first, then the directed ones; the last entry leaves
        // a nonzero Res for the reset-abort check.
        for (int i = 0; i < 6; i++) begin
            tbl[i].s = 1'($urandom);
            tbl[i].a = W'($urandom);
            tbl[i].b = W'($urandom);
            model(tbl[i].s, tbl[i].a, tbl[i].b, r, o);
            tbl[i].res = r;
            tbl[i].ovf = o;
            tbl[i].lat = (tbl[i].a == '0 || tbl[i].b == '0) ? 1 : 9;
        end
        tbl[6]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0, 9};
        tbl[7]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 9};
        tbl[8]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0, 9};
        tbl[9]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 1'b1, 9};
        tbl[10] = '{1'b1, 8'h80, 8'h01, 16'hFF80, 1'b0, 9};
        tbl[11] = '{1'b0, 8'h00, 8'h4D, 16'h0000, 1'b0, 1};
        tbl[12] = '{1'b1, 8'h00, 8'h85, 16'h0000, 1'b0, 1};
        tbl[13] = '{1'b0, 8'h4D, 8'h00, 16'h0000, 1'b0, 1};
        tbl[14] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b1, 9};
        tbl[15] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF, 1'b0, 9};
        tbl[16] = '{1'b0, 8'h10, 8'h0F, 16'h00F0, 1'b0, 9};
        tbl[17] = '{1'b0, 8'h10, 8'h10, 16'h0100, 1'b1, 9};

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            launch0(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].ovf);
            wait_done0(tbl[i].lat);
            @(negedge clk);
            chk("done_one_cycle", int'(done0), 0);
            chk("idle_after_done", int'(busy0), 0);
        end

        // Reset in mid-RUN (count=4) discards the operation.
        @(negedge clk);
        launch0(1'b0, 8'h12, 8'h34, 16'h03A8, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", int'(busy0), 0);
        chk("abort_res", int'(Res0), 0);
        chk("abort_ovf", int'(OVF0), 0);
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done0) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        launch0(1'b0, 8'd7, 8'd6, 16'd42, 1'b0);
        wait_done0(9);

        // start pulse during RUN is ignored.
        @(negedge clk);
        launch0(1'b0, 8'h0C, 8'h0B, 16'h0084, 1'b0);
        repeat (2) @(negedge clk);
        start0 = 1'b1; sgn0 = 1'b1; A0 = 8'hFF; B0 = 8'hFF;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(6);

        // Back-to-back: start held during the done cycle.
        @(negedge clk);
        launch0(1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0);
        wait_done0(9);
        launch0(1'b1, 8'h80, 8'h80, 16'h4000, 1'b1);
        wait_done0(9);

        // Without the shortcut a zero operand takes the full path.
        op1(1'b0, 8'h00, 8'h4D, 16'h0000, 1'b0, 9);
        op1(1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0, 9);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
